pipe_controller: RTL
====================

PIPE_CONTROLLER -- requirements
Module: pipe_controller

Interface
REQ-001 The module SHALL provide parameter REG_AW, default 5, meaning register-address width.
REQ-002 The module SHALL provide parameter JUMP_EN, default 1, meaning 1 decodes JAL/JALR/LUI and 0 treats them as illegal.
REQ-003 The module SHALL provide these ports, clock and reset first:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- id_valid  in  1  ID stage holds a real instruction
- opcode  in  7  instruction[6:0]
- rs1, rs2, rd  in  REG_AW each  ID-stage register fields
- branch_taken  in  1  EX-stage branch/jump resolved taken
- stall  out  1  hold PC and IF/ID
- flush_ifid  out  1  squash IF/ID
- ex_alu_src  out  1
- ex_alu_op  out  2  00 ld/st, 01 branch, 10 integer, 11 pass-imm
- ex_branch, ex_jump, ex_illegal  out  1 each
- fwd_a, fwd_b  out  2 each  00 regfile, 10 EX/MEM, 01 MEM/WB
- mem_read, mem_write  out  1 each  MEM-stage controls
- wb_reg_write  out  1
- wb_src  out  2  00 ALU, 01 memory, 10 PC+4
- wb_rd  out  REG_AW

Function
REQ-004 Decode SHALL be combinational from opcode and SHALL be captured into ID/EX on the next rising edge, giving one-cycle latency to ex_* outputs.
REQ-005 The decode table SHALL be as follows, with every unlisted control 0:
- OP: reg_write, alu_op 10
- OP_IMM: reg_write, alu_src, alu_op 10
- LOAD: reg_write, alu_src, mem_read, wb_src 01, alu_op 00
- STORE: alu_src, mem_write, alu_op 00
- BRANCH: branch, alu_op 01
- JAL: reg_write, jump, wb_src 10
- JALR: reg_write, jump, alu_src, wb_src 10
- LUI: reg_write, alu_src, alu_op 11
REQ-006 Any other opcode with id_valid=1 SHALL load a bubble with ex_illegal=1.
REQ-007 With JUMP_EN=0, JAL, JALR and LUI SHALL be treated as illegal.
REQ-008 reg_write SHALL be forced to 0 when rd==0.
REQ-009 id_valid=0 SHALL load an all-zero bubble.
REQ-010 The control bundle SHALL advance ID/EX -> EX/MEM -> MEM/WB every cycle, carrying rd, reg_write, wb_src, mem_read and mem_write.
REQ-011 mem_* outputs SHALL be driven from EX/MEM; wb_* outputs SHALL be driven from MEM/WB.
REQ-012 Load-use hazard: stall SHALL be 1 combinationally when the ID/EX stage has mem_read=1, EX rd!=0, and EX rd equals rs1, or equals rs2 for OP/STORE/BRANCH.
REQ-013 While stall=1, ID/EX SHALL load a bubble, and the ID instruction SHALL be re-presented next cycle; stall SHALL last exactly one cycle per hazard.
REQ-014 When branch_taken=1, flush_ifid SHALL be 1 in the same cycle, ID/EX SHALL load a bubble at the next edge, and stall SHALL be forced to 0 (flush has priority).
REQ-015 Forwarding for source operand A (fwd_a, using EX rs1) SHALL select 10 when EX/MEM has reg_write, its rd!=0 and its rd equals EX rs1.
REQ-016 Otherwise fwd_a SHALL select 01 when MEM/WB has reg_write, its rd!=0 and its rd equals EX rs1; otherwise 00. fwd_b SHALL follow the same rules using EX rs2.
REQ-017 EX/MEM SHALL win when both EX/MEM and MEM/WB match.
REQ-018 ID/EX SHALL register rs1 and rs2 to support forwarding.

Reset
REQ-019 Assertion of rst_n=0 SHALL asynchronously clear all three stage registers to the bubble value, including mid-stall and mid-flush.
REQ-020 In reset, stall=0, flush_ifid=0 and every output SHALL be 0.
REQ-021 The first capture after deassertion SHALL occur on the first rising edge with rst_n=1.

Structure
REQ-022 The opcode constants, the ALU_op and wb_src encodings, and the packed control-bundle typedef SHALL reside in shared package riscv_ctrl_pkg.
REQ-023 Hazard and forwarding comparison logic SHALL be one sub-module, hazard_unit; decode and stage registers SHALL remain in pipe_controller.

Verification
REQ-024 The bench SHALL cover the following scenarios:
- LOAD rd=5, then OP rs1=5 -> stall=1 for one cycle, one bubble in EX, then fwd_a=01 when OP reaches EX.
- OP rd=3, then OP rs2=3 -> no stall, fwd_b=10; with one NOP between -> fwd_b=01.
- Both EX/MEM and MEM/WB write rd=7, EX rs1=7 -> fwd_a=10.
- branch_taken=1 in the same cycle as a load-use hazard -> stall=0, flush_ifid=1, ex_* all 0 next cycle.
- Opcode 7'b1111111, and JAL with JUMP_EN=0 -> ex_illegal=1, reg_write=0, mem_write=0.
- rst_n pulled low mid-stall with a LOAD in MEM -> mem_read=0, stall=0 immediately; OP rd=0 -> wb_reg_write=0 three cycles later.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared opcode constants, control encodings and pipeline control bundles
// for the in-order pipeline controller.
package riscv_ctrl_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_EXMEM   = 2'b10;
    localparam logic [1:0] FWD_MEMWB   = 2'b01;

    typedef enum logic [1:0] {
        ALU_LDST     = 2'b00,
        ALU_BRANCH   = 2'b01,
        ALU_INT      = 2'b10,
        ALU_PASS_IMM = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10
    } wb_src_e;

    typedef struct packed {
        logic    reg_write;
        logic    alu_src;
        alu_op_e alu_op;
        logic    branch;
        logic    jump;
        logic    illegal;
        logic    mem_read;
        logic    mem_write;
        wb_src_e wb_src;
    } ctrl_t;

    typedef struct packed {
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        wb_src_e wb_src;
    } mem_ctrl_t;

    typedef struct packed {
        logic    reg_write;
        wb_src_e wb_src;
    } wb_ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '{
        reg_write: 1'b0, alu_src: 1'b0, alu_op: ALU_LDST, branch: 1'b0,
        jump: 1'b0, illegal: 1'b0, mem_read: 1'b0, mem_write: 1'b0, wb_src: WB_ALU
    };

    localparam mem_ctrl_t MEM_BUBBLE = '{
        reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0, wb_src: WB_ALU
    };

    localparam wb_ctrl_t WB_BUBBLE = '{reg_write: 1'b0, wb_src: WB_ALU};

    // Jump-class opcodes decode to an illegal bubble when jumps are disabled.
    function automatic ctrl_t decode_opcode(input logic [6:0] opcode, input logic jump_en);
        ctrl_t c;
        c = CTRL_BUBBLE;
        case (opcode)
            OPC_OP: begin
                c.reg_write = 1'b1;
                c.alu_op    = ALU_INT;
            end
            OPC_OP_IMM: begin
                c.reg_write = 1'b1;
                c.alu_src   = 1'b1;
                c.alu_op    = ALU_INT;
            end
            OPC_LOAD: begin
                c.reg_write = 1'b1;
                c.alu_src   = 1'b1;
                c.mem_read  = 1'b1;
                c.wb_src    = WB_MEM;
            end
            OPC_STORE: begin
                c.alu_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            OPC_BRANCH: begin
                c.branch = 1'b1;
                c.alu_op = ALU_BRANCH;
            end
            OPC_JAL: begin
                if (jump_en) begin
                    c.reg_write = 1'b1;
                    c.jump      = 1'b1;
                    c.wb_src    = WB_PC4;
                end else begin
                    c.illegal = 1'b1;
                end
            end
            OPC_JALR: begin
                if (jump_en) begin
                    c.reg_write = 1'b1;
                    c.jump      = 1'b1;
                    c.alu_src   = 1'b1;
                    c.wb_src    = WB_PC4;
                end else begin
                    c.illegal = 1'b1;
                end
            end
            OPC_LUI: begin
                if (jump_en) begin
                    c.reg_write = 1'b1;
                    c.alu_src   = 1'b1;
                    c.alu_op    = ALU_PASS_IMM;
                end else begin
                    c.illegal = 1'b1;
                end
            end
            default: c.illegal = 1'b1;
        endcase
        return c;
    endfunction

    // Only these formats carry a real rs2 operand worth stalling on.
    function automatic logic reads_rs2(input logic [6:0] opcode);
        logic r;
        case (opcode)
            OPC_OP, OPC_STORE, OPC_BRANCH: r = 1'b1;
            default:                       r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pipe_controller_if.sv
// Bundle of the controller's ID-stage inputs and pipeline control outputs;
// master drives instructions in, slave is the controller's view.
interface pipe_controller_if #(parameter int REG_AW = 5);
    logic              id_valid;
    logic [6:0]        opcode;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic              branch_taken;
    logic              stall;
    logic              flush_ifid;
    logic              ex_alu_src;
    logic [1:0]        ex_alu_op;
    logic              ex_branch;
    logic              ex_jump;
    logic              ex_illegal;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic              mem_read;
    logic              mem_write;
    logic              wb_reg_write;
    logic [1:0]        wb_src;
    logic [REG_AW-1:0] wb_rd;

    modport master (
        output id_valid, opcode, rs1, rs2, rd, branch_taken,
        input  stall, flush_ifid, ex_alu_src, ex_alu_op, ex_branch, ex_jump, ex_illegal,
        input  fwd_a, fwd_b, mem_read, mem_write, wb_reg_write, wb_src, wb_rd
    );

    modport slave (
        input  id_valid, opcode, rs1, rs2, rd, branch_taken,
        output stall, flush_ifid, ex_alu_src, ex_alu_op, ex_branch, ex_jump, ex_illegal,
        output fwd_a, fwd_b, mem_read, mem_write, wb_reg_write, wb_src, wb_rd
    );
endinterface

// File: rtl/hazard_unit.sv
// Load-use stall detection and EX operand forwarding selection; purely
// combinational over the ID fields and the three stage registers.
module hazard_unit
    import riscv_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_reads_rs2,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [REG_AW-1:0] ex_rs1,
    input  logic [REG_AW-1:0] ex_rs2,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              branch_taken,
    output logic              stall,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b
);

    localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};

    logic load_use_s;

    // The younger producer (EX/MEM) wins over MEM/WB when both match.
    function automatic logic [1:0] fwd_select(input logic [REG_AW-1:0] src);
        logic [1:0] sel;
        if (mem_reg_write && (mem_rd != REG_ZERO) && (mem_rd == src)) begin
            sel = FWD_EXMEM;
        end else if (wb_reg_write && (wb_rd != REG_ZERO) && (wb_rd == src)) begin
            sel = FWD_MEMWB;
        end else begin
            sel = FWD_REGFILE;
        end
        return sel;
    endfunction

    // Stall on load-use unless a taken branch is squashing the ID instruction anyway.
    always_comb begin
        load_use_s = ex_mem_read && (ex_rd != REG_ZERO) &&
                     ((ex_rd == id_rs1) || (id_reads_rs2 && (ex_rd == id_rs2)));
        stall = load_use_s & ~branch_taken;
        fwd_a = fwd_select(ex_rs1);
        fwd_b = fwd_select(ex_rs2);
    end

endmodule

// File: rtl/pipe_controller.sv
// Five-stage pipeline controller: opcode decode into ID/EX, control bundle
// propagation to EX/MEM and MEM/WB, with hazard/forwarding from hazard_unit.
module pipe_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter bit JUMP_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [6:0]        opcode,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic [REG_AW-1:0] rd,
    input  logic              branch_taken,
    output logic              stall,
    output logic              flush_ifid,
    output logic              ex_alu_src,
    output logic [1:0]        ex_alu_op,
    output logic              ex_branch,
    output logic              ex_jump,
    output logic              ex_illegal,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              mem_read,
    output logic              mem_write,
    output logic              wb_reg_write,
    output logic [1:0]        wb_src,
    output logic [REG_AW-1:0] wb_rd
);

    localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};

    ctrl_t             id_ctrl_s;
    logic              id_reads_rs2_s;
    ctrl_t             idex_ctrl_next_s;
    logic [REG_AW-1:0] idex_rd_next_s;
    logic [REG_AW-1:0] idex_rs1_next_s;
    logic [REG_AW-1:0] idex_rs2_next_s;
    logic              stall_s;

    ctrl_t             idex_ctrl_r;
    logic [REG_AW-1:0] idex_rd_r;
    logic [REG_AW-1:0] idex_rs1_r;
    logic [REG_AW-1:0] idex_rs2_r;
    mem_ctrl_t         exmem_ctrl_r;
    logic [REG_AW-1:0] exmem_rd_r;
    wb_ctrl_t          memwb_ctrl_r;
    logic [REG_AW-1:0] memwb_rd_r;

    // Decode the ID instruction and choose what ID/EX captures next.
    always_comb begin
        id_ctrl_s           = decode_opcode(opcode, JUMP_EN);
        id_ctrl_s.reg_write = id_ctrl_s.reg_write & (rd != REG_ZERO);
        id_reads_rs2_s      = reads_rs2(opcode);
        idex_ctrl_next_s    = CTRL_BUBBLE;
        idex_rd_next_s      = REG_ZERO;
        idex_rs1_next_s     = REG_ZERO;
        idex_rs2_next_s     = REG_ZERO;
        if (!id_valid || stall_s || branch_taken) begin
            idex_ctrl_next_s = CTRL_BUBBLE;
        end else if (id_ctrl_s.illegal) begin
            // Illegal opcodes enter EX as a bubble that only flags the fault.
            idex_ctrl_next_s = id_ctrl_s;
        end else begin
            idex_ctrl_next_s = id_ctrl_s;
            idex_rd_next_s   = rd;
            idex_rs1_next_s  = rs1;
            idex_rs2_next_s  = rs2;
        end
    end

    hazard_unit #(.REG_AW(REG_AW)) u_hazard (
        .id_rs1        (rs1),
        .id_rs2        (rs2),
        .id_reads_rs2  (id_reads_rs2_s),
        .ex_mem_read   (idex_ctrl_r.mem_read),
        .ex_rd         (idex_rd_r),
        .ex_rs1        (idex_rs1_r),
        .ex_rs2        (idex_rs2_r),
        .mem_reg_write (exmem_ctrl_r.reg_write),
        .mem_rd        (exmem_rd_r),
        .wb_reg_write  (memwb_ctrl_r.reg_write),
        .wb_rd         (memwb_rd_r),
        .branch_taken  (branch_taken),
        .stall         (stall_s),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b)
    );

    // Stage registers: ID/EX -> EX/MEM -> MEM/WB advance every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_ctrl_r  <= CTRL_BUBBLE;
            idex_rd_r    <= REG_ZERO;
            idex_rs1_r   <= REG_ZERO;
            idex_rs2_r   <= REG_ZERO;
            exmem_ctrl_r <= MEM_BUBBLE;
            exmem_rd_r   <= REG_ZERO;
            memwb_ctrl_r <= WB_BUBBLE;
            memwb_rd_r   <= REG_ZERO;
        end else begin
            idex_ctrl_r            <= idex_ctrl_next_s;
            idex_rd_r              <= idex_rd_next_s;
            idex_rs1_r             <= idex_rs1_next_s;
            idex_rs2_r             <= idex_rs2_next_s;
            exmem_ctrl_r.reg_write <= idex_ctrl_r.reg_write;
            exmem_ctrl_r.mem_read  <= idex_ctrl_r.mem_read;
            exmem_ctrl_r.mem_write <= idex_ctrl_r.mem_write;
            exmem_ctrl_r.wb_src    <= idex_ctrl_r.wb_src;
            exmem_rd_r             <= idex_rd_r;
            memwb_ctrl_r.reg_write <= exmem_ctrl_r.reg_write;
            memwb_ctrl_r.wb_src    <= exmem_ctrl_r.wb_src;
            memwb_rd_r             <= exmem_rd_r;
        end
    end

    assign stall        = stall_s;
    assign flush_ifid   = branch_taken & rst_n;
    assign ex_alu_src   = idex_ctrl_r.alu_src;
    assign ex_alu_op    = idex_ctrl_r.alu_op;
    assign ex_branch    = idex_ctrl_r.branch;
    assign ex_jump      = idex_ctrl_r.jump;
    assign ex_illegal   = idex_ctrl_r.illegal;
    assign mem_read     = exmem_ctrl_r.mem_read;
    assign mem_write    = exmem_ctrl_r.mem_write;
    assign wb_reg_write = memwb_ctrl_r.reg_write;
    assign wb_src       = memwb_ctrl_r.wb_src;
    assign wb_rd        = memwb_rd_r;

endmodule
